// File: rtl/attn_value_mixer.sv
// Attention value mixer: latches one softmax probability vector, accumulates p[i]*V[i][d]
// over VECTOR_LEN value rows and emits a rounded, saturated Q8.8 context vector.
module attn_value_mixer #(
    parameter int VECTOR_LEN = 4,
    parameter int HEAD_DIM   = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             prob_valid,
    input  logic [VECTOR_LEN*8-1:0]          prob_in,
    output logic                             prob_ready,
    input  logic                             v_valid,
    input  logic [HEAD_DIM*DATA_WIDTH-1:0]   v_in,
    output logic                             v_ready,
    output logic [HEAD_DIM*DATA_WIDTH-1:0]   out_vec,
    output logic                             valid_out
);

    localparam int unsigned DW     = DATA_WIDTH;
    localparam int unsigned PROD_W = DW + 9;
    localparam int unsigned ACC_W  = DW + 9 + $clog2(VECTOR_LEN);
    localparam int unsigned IDX_W  = (VECTOR_LEN > 1) ? $clog2(VECTOR_LEN) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [7:0]              prob_q [VECTOR_LEN];
    logic signed [ACC_W-1:0] acc    [HEAD_DIM];
    logic [IDX_W-1:0]        row_idx;

    logic                     last_row_c;
    logic signed [8:0]        p_ext_c;
    logic signed [PROD_W-1:0] prod_c [HEAD_DIM];
    logic [HEAD_DIM*DW-1:0]   res_c;

    assign last_row_c = (row_idx == IDX_W'(VECTOR_LEN - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (prob_valid) state_nxt = ACCUM;
            ACCUM:   if (v_valid && last_row_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // One Q0.8 x Q8.8 product per output lane, probability zero-extended to stay positive
    always_comb begin
        p_ext_c = $signed({1'b0, prob_q[row_idx]});
        for (int d = 0; d < HEAD_DIM; d++) begin
            prod_c[d] = PROD_W'(p_ext_c) * PROD_W'($signed(v_in[d*DW +: DW]));
        end
    end

    // Round half toward +inf, then clamp to the Q8.8 range
    always_comb begin
        logic signed [ACC_W-1:0] rnd;
        rnd   = '0;
        res_c = '0;
        for (int d = 0; d < HEAD_DIM; d++) begin
            rnd = (acc[d] + $signed(ACC_W'(128))) >>> 8;
            if (rnd > SAT_HI)      res_c[d*DW +: DW] = SAT_HI[DW-1:0];
            else if (rnd < SAT_LO) res_c[d*DW +: DW] = SAT_LO[DW-1:0];
            else                   res_c[d*DW +: DW] = rnd[DW-1:0];
        end
    end

    // Datapath and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx    <= '0;
            out_vec    <= '0;
            valid_out  <= 1'b0;
            prob_ready <= 1'b1;
            v_ready    <= 1'b0;
            for (int i = 0; i < VECTOR_LEN; i++) prob_q[i] <= '0;
            for (int d = 0; d < HEAD_DIM; d++)   acc[d]    <= '0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (prob_valid) begin
                        for (int i = 0; i < VECTOR_LEN; i++) prob_q[i] <= prob_in[i*8 +: 8];
                        for (int d = 0; d < HEAD_DIM; d++)   acc[d]    <= '0;
                        row_idx    <= '0;
                        prob_ready <= 1'b0;
                        v_ready    <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (v_valid) begin
                        for (int d = 0; d < HEAD_DIM; d++) acc[d] <= acc[d] + ACC_W'(prod_c[d]);
                        row_idx <= row_idx + IDX_W'(1);
                        if (last_row_c) v_ready <= 1'b0;
                    end
                end
                DONE: begin
                    out_vec    <= res_c;
                    valid_out  <= 1'b1;
                    prob_ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_value_mixer.sv
// Directed self-checking bench for attn_value_mixer with an arithmetic reference model
// and a per-cycle result checker fed from an expectation queue.
module tb_attn_value_mixer;

    localparam int N  = 4;
    localparam int HD = 4;
    localparam int DW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              prob_valid;
    logic [N*8-1:0]    prob_in;
    logic              prob_ready;
    logic              v_valid;
    logic [HD*DW-1:0]  v_in;
    logic              v_ready;
    logic [HD*DW-1:0]  out_vec;
    logic              valid_out;

    int errors = 0;
    int checks = 0;
    logic [HD*DW-1:0] exp_q[$];

    attn_value_mixer #(.VECTOR_LEN(N), .HEAD_DIM(HD), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .prob_valid(prob_valid), .prob_in(prob_in), .prob_ready(prob_ready),
        .v_valid(v_valid), .v_in(v_in), .v_ready(v_ready),
        .out_vec(out_vec), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer dot product, floor((sum+128)/256), clamp to 16-bit signed
    function automatic logic [HD*DW-1:0] model(input int p[N], input int v[N][HD]);
        logic [HD*DW-1:0] r;
        longint s;
        r = '0;
        for (int d = 0; d < HD; d++) begin
            s = 0;
            for (int i = 0; i < N; i++) s += longint'(p[i]) * longint'(v[i][d]);
            s = (s + 128) >>> 8;
            if (s > 32767)  s = 32767;
            if (s < -32768) s = -32768;
            r[d*DW +: DW] = DW'(s);
        end
        return r;
    endfunction

    // Every valid_out must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_out: got out_vec %h expected no result", out_vec);
            end else begin
                check("result_vs_model", 64'(out_vec), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic send_prob(input int p[N]);
        check("prob_ready_idle", 64'(prob_ready), 64'd1);
        check("v_ready_idle", 64'(v_ready), 64'd0);
        for (int i = 0; i < N; i++) prob_in[i*8 +: 8] = 8'(p[i]);
        prob_valid = 1'b1;
        @(posedge clk); #1;
        prob_valid = 1'b0;
    endtask

    task automatic send_row(input int row[HD], input bit abuse);
        check("v_ready_accum", 64'(v_ready), 64'd1);
        check("prob_ready_accum", 64'(prob_ready), 64'd0);
        for (int d = 0; d < HD; d++) v_in[d*DW +: DW] = DW'(row[d]);
        v_valid = 1'b1;
        if (abuse) begin
            prob_in    = {8'd0, 8'd0, 8'd0, 8'd255};
            prob_valid = 1'b1;
        end
        @(posedge clk); #1;
        v_valid    = 1'b0;
        prob_valid = 1'b0;
    endtask

    task automatic run_txn(input int p[N], input int v[N][HD], input int stall, input bit abuse);
        int row[HD];
        exp_q.push_back(model(p, v));
        send_prob(p);
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < stall; s++) begin
                check("v_ready_stall", 64'(v_ready), 64'd1);
                @(posedge clk); #1;
            end
            for (int d = 0; d < HD; d++) row[d] = v[i][d];
            send_row(row, abuse && (i == 1));
        end
        check("valid_out_latency_e1", 64'(valid_out), 64'd0);
        check("prob_ready_done", 64'(prob_ready), 64'd0);
        check("v_ready_done", 64'(v_ready), 64'd0);
        @(posedge clk); #1;
        check("valid_out_latency_e2", 64'(valid_out), 64'd1);
        check("prob_ready_result_edge", 64'(prob_ready), 64'd1);
        @(posedge clk); #1;
        check("valid_out_single_cycle", 64'(valid_out), 64'd0);
    endtask

    int p_uni[N]     = '{64, 64, 64, 64};
    int p_hot[N]     = '{0, 0, 0, 255};
    int p_full[N]    = '{255, 255, 255, 255};
    int p_mix[N]     = '{10, 200, 30, 16};
    int v_uni[N][HD] = '{'{256, 256, 256, 256}, '{256, 256, 256, 256},
                         '{256, 256, 256, 256}, '{256, 256, 256, 256}};
    int v_hot[N][HD] = '{'{1000, 1000, 1000, 1000}, '{1000, 1000, 1000, 1000},
                         '{1000, 1000, 1000, 1000}, '{256, -512, 1000, 0}};
    int v_max[N][HD] = '{'{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767},
                         '{32767, 32767, 32767, 32767}, '{32767, 32767, 32767, 32767}};
    int v_min[N][HD] = '{'{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768},
                         '{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}};
    int v_mix[N][HD] = '{'{300, -700, 12, 0}, '{-1, 513, 2560, -2560},
                         '{7000, -7000, 128, 77}, '{-300, 1, -129, 32767}};

    localparam logic [63:0] OUT_UNI = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    localparam logic [63:0] OUT_HOT = {16'h0000, 16'h03E4, 16'hFE02, 16'h00FF};
    localparam logic [63:0] OUT_MAX = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    localparam logic [63:0] OUT_MIN = {16'h8000, 16'h8000, 16'h8000, 16'h8000};

    initial begin
        int row[HD];
        rst        = 1'b1;
        prob_valid = 1'b0;
        prob_in    = '0;
        v_valid    = 1'b0;
        v_in       = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid_out", 64'(valid_out), 64'd0);
        check("reset_prob_ready", 64'(prob_ready), 64'd1);
        check("reset_v_ready", 64'(v_ready), 64'd0);
        check("reset_out_vec", 64'(out_vec), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_txn(p_uni, v_uni, 0, 1'b0);
        check("uniform_literal", 64'(out_vec), OUT_UNI);

        run_txn(p_hot, v_hot, 0, 1'b0);
        check("onehot_literal", 64'(out_vec), OUT_HOT);

        run_txn(p_full, v_max, 0, 1'b0);
        check("sat_pos_literal", 64'(out_vec), OUT_MAX);

        run_txn(p_full, v_min, 0, 1'b0);
        check("sat_neg_literal", 64'(out_vec), OUT_MIN);
        repeat (3) @(posedge clk);
        #1;
        check("out_vec_hold", 64'(out_vec), OUT_MIN);

        run_txn(p_uni, v_uni, 3, 1'b0);
        check("stall_literal", 64'(out_vec), OUT_UNI);

        run_txn(p_mix, v_mix, 1, 1'b0);

        run_txn(p_uni, v_uni, 0, 1'b1);
        check("prob_abuse_literal", 64'(out_vec), OUT_UNI);

        // V rows offered while idle must not leak into the next sum
        run_txn(p_hot, v_hot, 0, 1'b0);
        for (int d = 0; d < HD; d++) v_in[d*DW +: DW] = 16'd1000;
        v_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_v_ignored_v_ready", 64'(v_ready), 64'd0);
        v_valid = 1'b0;
        run_txn(p_uni, v_uni, 0, 1'b0);
        check("idle_v_literal", 64'(out_vec), OUT_UNI);

        // Abort after two accepted rows
        send_prob(p_hot);
        for (int i = 0; i < 2; i++) begin
            for (int d = 0; d < HD; d++) row[d] = v_hot[i][d];
            send_row(row, 1'b0);
        end
        rst = 1'b1;
        #1;
        check("abort_valid_out", 64'(valid_out), 64'd0);
        check("abort_prob_ready", 64'(prob_ready), 64'd1);
        check("abort_v_ready", 64'(v_ready), 64'd0);
        check("abort_out_vec", 64'(out_vec), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_result", 64'(valid_out), 64'd0);
        run_txn(p_uni, v_uni, 0, 1'b0);
        check("after_abort_literal", 64'(out_vec), OUT_UNI);

        repeat (2) @(posedge clk);
        #1;
        check("all_results_seen", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
